// File: rtl/add_result_fifo.sv
// ---------------------------------------------------------------------------
// add_result_fifo
//
// Result buffer behind the 32-bit carry-skip adder. Each 33-bit sum
// {cout, s[31:0]} is captured into a small synchronous FIFO with a
// valid/ready handshake on both sides. This lets the combinational adder run
// ahead of a slower consumer. A saturating counter records how many accepted
// words had the carry-out bit set.
//
// Parameters
//   WIDTH : result word width; bit WIDTH-1 is the carry-out
//   DEPTH : FIFO entries (power of two, >= 2)
//   CNT_W : width of the carry-out statistics counter
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (pointers, occupancy, stats)
//   in_valid   : upstream presents a sum on in_sum
//   in_sum     : adder result {cout, s}
//   in_ready   : FIFO can accept a word this cycle (registered state only)
//   out_valid  : head word is available
//   out_sum    : head word, forced to zero when the FIFO is empty
//   out_ready  : consumer accepts the head word
//   count      : current occupancy, 0..DEPTH
//   carry_cnt  : saturating count of accepted words with the carry bit set
//   clr_stats  : synchronous clear of carry_cnt; wins over an increment
// ---------------------------------------------------------------------------
module add_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_sum,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_sum,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         carry_cnt,
    input  logic                     clr_stats
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic [CNT_W-1:0] carry_q,  carry_d;

    logic push;
    logic pop;
    logic full;
    logic empty;

    // Handshake qualifiers come from the registered occupancy only, so there
    // is no combinational path from out_ready to in_ready.
    assign full  = (count_q == OCC_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = in_valid  & ~full;
    assign pop   = out_ready & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        carry_d  = carry_q;

        // Pointers are exactly log2(DEPTH) bits, so wrap is free.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (clr_stats) begin
            carry_d = '0;
        end else if (push && in_sum[WIDTH-1]) begin
            carry_d = sat_inc(carry_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            carry_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are never
    // visible because out_sum is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_sum;
        end
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_sum   = empty ? '0 : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign carry_cnt = carry_q;

endmodule
